// File: rtl/cp0_regfile_pkg.sv
// Shared definitions for the CP0 register file: exception kind encoding,
// CP0 register numbers, Status/Cause bit positions, ExcCode values and
// MTC0 write masks.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer present).
package cp0_regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned EXC_TYPE_W = 4;
    localparam int unsigned HW_INT_W   = 6;
    localparam int unsigned CE_W       = 2;
    localparam int unsigned EXCCODE_W  = 5;
    localparam int unsigned IP_W       = 8;

    // Exception kind presented by MEM with exc_flag
    typedef enum logic [EXC_TYPE_W-1:0] {
        EXC_INTR = 4'd0,
        EXC_TLBM = 4'd1,
        EXC_TLBR = 4'd2,
        EXC_TLBI = 4'd3,
        EXC_ADE  = 4'd4,
        EXC_SYSC = 4'd5,
        EXC_BP   = 4'd6,
        EXC_RI   = 4'd7,
        EXC_CPU  = 4'd8,
        EXC_OV   = 4'd9,
        EXC_TRAP = 4'd10,
        EXC_ERET = 4'd11
    } exc_type_e;

    // CP0 register numbers (sel 0)
    localparam logic [REG_AW-1:0] REG_BADVADDR = 5'd8;
    localparam logic [REG_AW-1:0] REG_COUNT    = 5'd9;
    localparam logic [REG_AW-1:0] REG_COMPARE  = 5'd11;
    localparam logic [REG_AW-1:0] REG_STATUS   = 5'd12;
    localparam logic [REG_AW-1:0] REG_CAUSE    = 5'd13;
    localparam logic [REG_AW-1:0] REG_EPC      = 5'd14;
    localparam logic [REG_AW-1:0] REG_PRID     = 5'd15;
    localparam logic [REG_AW-1:0] REG_CONFIG   = 5'd16;
    localparam logic [REG_AW-1:0] REG_ERROREPC = 5'd30;

    // Status / Cause bit positions
    localparam int unsigned ST_IE      = 0;
    localparam int unsigned ST_EXL     = 1;
    localparam int unsigned ST_ERL     = 2;
    localparam int unsigned ST_BEV     = 22;
    localparam int unsigned CA_EXC_LO  = 2;
    localparam int unsigned IP_LO      = 8;
    localparam int unsigned CA_IPHW_LO = 10;
    localparam int unsigned CA_IV      = 23;
    localparam int unsigned CA_CE_LO   = 28;
    localparam int unsigned CA_TI      = 30;
    localparam int unsigned CA_BD      = 31;

    // ExcCode values
    localparam logic [EXCCODE_W-1:0] EC_INT  = 5'd0;
    localparam logic [EXCCODE_W-1:0] EC_MOD  = 5'd1;
    localparam logic [EXCCODE_W-1:0] EC_TLBL = 5'd2;
    localparam logic [EXCCODE_W-1:0] EC_TLBS = 5'd3;
    localparam logic [EXCCODE_W-1:0] EC_ADEL = 5'd4;
    localparam logic [EXCCODE_W-1:0] EC_ADES = 5'd5;
    localparam logic [EXCCODE_W-1:0] EC_SYS  = 5'd8;
    localparam logic [EXCCODE_W-1:0] EC_BP   = 5'd9;
    localparam logic [EXCCODE_W-1:0] EC_RI   = 5'd10;
    localparam logic [EXCCODE_W-1:0] EC_CPU  = 5'd11;
    localparam logic [EXCCODE_W-1:0] EC_OV   = 5'd12;
    localparam logic [EXCCODE_W-1:0] EC_TR   = 5'd13;

    // Constants and masks
    localparam logic [XLEN-1:0] PRID             = 32'h0001_8000;
    localparam logic [XLEN-1:0] CONFIG           = 32'h8000_0000;
    localparam logic [XLEN-1:0] STATUS_RESET     = 32'h0040_0004;
    localparam logic [XLEN-1:0] STATUS_WMASK     = 32'h1040_FF07;
    localparam logic [XLEN-1:0] CAUSE_WMASK      = 32'h0080_0300;
    // Cause bits held in the cause flop (BD, CE, IV, IP[1:0], ExcCode)
    localparam logic [XLEN-1:0] CAUSE_STORE_MASK = 32'hB080_037C;

    // MTC0-writable bits of each CP0 register; zero means read-only/absent
    function automatic logic [XLEN-1:0] cp0_wmask(input logic [REG_AW-1:0] addr);
        logic [XLEN-1:0] m;
        m = '0;
        case (addr)
            REG_STATUS:   m = STATUS_WMASK;
            REG_CAUSE:    m = CAUSE_WMASK;
            REG_EPC:      m = '1;
            REG_ERROREPC: m = '1;
`ifdef CP0_TIMER_EN
            REG_COUNT:    m = '1;
            REG_COMPARE:  m = '1;
`endif
            default:      m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count advances every second cycle and wraps; TI sets
// when Count steps onto Compare and clears only on a Compare write.
// Ports: clk, resetn (sync, active-low), wen_count_i/wen_compare_i load
// strobes with wdata_i, count_o/compare_o/ti_o register views.
// Instantiated only when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            wen_count_i,
    input  logic            wen_compare_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] count_o,
    output logic [XLEN-1:0] compare_o,
    output logic            ti_o
);

    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] compare_q, compare_d;
    logic            tick_q, tick_d;
    logic            ti_q, ti_d;

    // Next-state: tick/increment, then MTC0 loads take priority
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        tick_d    = ~tick_q;
        ti_d      = ti_q;
        if (tick_q) begin
            count_d = XLEN'(count_q + 32'd1);
            // match is taken on the value Count steps onto
            if (count_d == compare_q) begin
                ti_d = 1'b1;
            end
        end
        if (wen_count_i) begin
            count_d = wdata_i;
            tick_d  = 1'b0;
        end
        if (wen_compare_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception-commit unit. Commits MEM exceptions and
// ERET, services MTC0 (wen/waddr/wdata) and MFC0 (raddr/rdata, combinational),
// samples int_i into Cause.IP[7:2] and raises intr_req. cp0_Status/Cause/
// EPC/ErrorEPC and rdata forward a same-cycle MTC0 write.
// Optional feature macro: CP0_TIMER_EN (Count/Compare via cp0_timer).
module cp0_regfile
    import cp0_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [HW_INT_W-1:0]   int_i,
    input  logic                  wen,
    input  logic [REG_AW-1:0]     waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_AW-1:0]     raddr,
    output logic [XLEN-1:0]       rdata,
    input  logic                  exc_flag,
    input  logic [EXC_TYPE_W-1:0] exc_type,
    input  logic [XLEN-1:0]       exc_pc,
    input  logic                  exc_ds,
    input  logic                  exc_store,
    input  logic [XLEN-1:0]       exc_badva,
    input  logic [CE_W-1:0]       exc_ce,
    output logic                  intr_req,
    output logic [XLEN-1:0]       cp0_Status,
    output logic [XLEN-1:0]       cp0_Cause,
    output logic [XLEN-1:0]       cp0_EPC,
    output logic [XLEN-1:0]       cp0_ErrorEPC
);

    logic [XLEN-1:0]     status_q, status_d;
    logic [XLEN-1:0]     cause_q, cause_d;
    logic [XLEN-1:0]     epc_q, epc_d;
    logic [XLEN-1:0]     errorepc_q, errorepc_d;
    logic [XLEN-1:0]     badvaddr_q, badvaddr_d;
    logic [HW_INT_W-1:0] ip_hw_q;

    logic [XLEN-1:0]      count, compare;
    logic                 ti;
    logic [XLEN-1:0]      cause_view, status_w, cause_w, epc_w, errorepc_w;
    logic [XLEN-1:0]      rd_view;
    logic [EXCCODE_W-1:0] exccode;
    logic                 badva_en, is_cpu;
    exc_type_e            exc_kind;

    // Merge a same-cycle MTC0 into a register view under its write mask
    function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] a,
                                            input logic [XLEN-1:0]   v,
                                            input logic              we,
                                            input logic [REG_AW-1:0] wa,
                                            input logic [XLEN-1:0]   wd);
        logic [XLEN-1:0] m;
        m = cp0_wmask(a);
        return (we && (wa == a)) ? ((v & ~m) | (wd & m)) : v;
    endfunction

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk           (clk),
        .resetn        (resetn),
        .wen_count_i   (wen && (waddr == REG_COUNT)),
        .wen_compare_i (wen && (waddr == REG_COMPARE)),
        .wdata_i       (wdata),
        .count_o       (count),
        .compare_o     (compare),
        .ti_o          (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    assign exc_kind = exc_type_e'(exc_type);

    // Cause as seen by software: stored fields plus live TI and hardware IP
    assign cause_view = (cause_q & CAUSE_STORE_MASK)
                      | (XLEN'(ti) << CA_TI)
                      | (XLEN'({ip_hw_q[5] | ti, ip_hw_q[4:0]}) << CA_IPHW_LO);

    assign status_w   = fwd(REG_STATUS,   status_q,   wen, waddr, wdata);
    assign cause_w    = fwd(REG_CAUSE,    cause_q,    wen, waddr, wdata);
    assign epc_w      = fwd(REG_EPC,      epc_q,      wen, waddr, wdata);
    assign errorepc_w = fwd(REG_ERROREPC, errorepc_q, wen, waddr, wdata);

    assign cp0_Status   = status_w;
    assign cp0_Cause    = fwd(REG_CAUSE, cause_view, wen, waddr, wdata);
    assign cp0_EPC      = epc_w;
    assign cp0_ErrorEPC = errorepc_w;

    assign intr_req = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL]
                    & |(cause_view[IP_LO +: IP_W] & status_q[IP_LO +: IP_W]);

    // MFC0 read mux
    always_comb begin
        rd_view = '0;
        case (raddr)
            REG_BADVADDR: rd_view = badvaddr_q;
            REG_COUNT:    rd_view = count;
            REG_COMPARE:  rd_view = compare;
            REG_STATUS:   rd_view = status_q;
            REG_CAUSE:    rd_view = cause_view;
            REG_EPC:      rd_view = epc_q;
            REG_PRID:     rd_view = PRID;
            REG_CONFIG:   rd_view = CONFIG;
            REG_ERROREPC: rd_view = errorepc_q;
            default:      rd_view = '0;
        endcase
        rdata = fwd(raddr, rd_view, wen, waddr, wdata);
    end

    // Exception kind to ExcCode and BadVAddr capture
    always_comb begin
        exccode  = cause_w[CA_EXC_LO +: EXCCODE_W];
        badva_en = 1'b0;
        is_cpu   = 1'b0;
        case (exc_kind)
            EXC_INTR: exccode = EC_INT;
            EXC_TLBM: begin exccode = EC_MOD; badva_en = 1'b1; end
            EXC_TLBR,
            EXC_TLBI: begin exccode = exc_store ? EC_TLBS : EC_TLBL; badva_en = 1'b1; end
            EXC_ADE:  begin exccode = exc_store ? EC_ADES : EC_ADEL; badva_en = 1'b1; end
            EXC_SYSC: exccode = EC_SYS;
            EXC_BP:   exccode = EC_BP;
            EXC_RI:   exccode = EC_RI;
            EXC_CPU:  begin exccode = EC_CPU; is_cpu = 1'b1; end
            EXC_OV:   exccode = EC_OV;
            EXC_TRAP: exccode = EC_TR;
            default:  ;
        endcase
    end

    // Next-state: MTC0 already merged into *_w, commit overrides its fields
    always_comb begin
        status_d   = status_w;
        cause_d    = cause_w;
        epc_d      = epc_w;
        errorepc_d = errorepc_w;
        badvaddr_d = badvaddr_q;
        if (exc_flag) begin
            if (exc_kind == EXC_ERET) begin
                if (status_w[ST_ERL]) begin
                    status_d[ST_ERL] = 1'b0;
                end else begin
                    status_d[ST_EXL] = 1'b0;
                end
            end else begin
                // nested exceptions keep the original return point
                if (!status_w[ST_EXL]) begin
                    epc_d          = exc_ds ? XLEN'(exc_pc - 32'd4) : exc_pc;
                    cause_d[CA_BD] = exc_ds;
                end
                status_d[ST_EXL]                = 1'b1;
                cause_d[CA_EXC_LO +: EXCCODE_W] = exccode;
                if (is_cpu) begin
                    cause_d[CA_CE_LO +: CE_W] = exc_ce;
                end
                if (badva_en) begin
                    badvaddr_d = exc_badva;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            errorepc_q <= '0;
            badvaddr_q <= '0;
            ip_hw_q    <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            errorepc_q <= errorepc_d;
            badvaddr_q <= badvaddr_d;
            ip_hw_q    <= int_i;
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset values, masked MTC0, exception and
// ERET commit, forwarding, hardware interrupt and (with CP0_TIMER_EN) timer.
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    logic        clk;
    logic        resetn;
    logic [5:0]  int_i;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        exc_flag;
    logic [3:0]  exc_type;
    logic [31:0] exc_pc;
    logic        exc_ds;
    logic        exc_store;
    logic [31:0] exc_badva;
    logic [1:0]  exc_ce;
    logic        intr_req;
    logic [31:0] cp0_Status, cp0_Cause, cp0_EPC, cp0_ErrorEPC;

    int n_checks = 0;
    int n_errors = 0;

    cp0_regfile dut (
        .clk          (clk),
        .resetn       (resetn),
        .int_i        (int_i),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        (raddr),
        .rdata        (rdata),
        .exc_flag     (exc_flag),
        .exc_type     (exc_type),
        .exc_pc       (exc_pc),
        .exc_ds       (exc_ds),
        .exc_store    (exc_store),
        .exc_badva    (exc_badva),
        .exc_ce       (exc_ce),
        .intr_req     (intr_req),
        .cp0_Status   (cp0_Status),
        .cp0_Cause    (cp0_Cause),
        .cp0_EPC      (cp0_EPC),
        .cp0_ErrorEPC (cp0_ErrorEPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        raddr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        step();
        wen   = 1'b0;
    endtask

    task automatic commit(input exc_type_e t, input logic [31:0] pc, input logic ds,
                          input logic st, input logic [31:0] va, input logic [1:0] ce);
        exc_flag  = 1'b1;
        exc_type  = t;
        exc_pc    = pc;
        exc_ds    = ds;
        exc_store = st;
        exc_badva = va;
        exc_ce    = ce;
        step();
        exc_flag  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; int_i = '0; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        exc_flag = 1'b0; exc_type = EXC_INTR; exc_pc = '0; exc_ds = 1'b0;
        exc_store = 1'b0; exc_badva = '0; exc_ce = '0;
        repeat (3) step();

        // Reset state
        rd(REG_STATUS, 32'h0040_0004, "rst_status");
        rd(REG_CAUSE,  32'h0,         "rst_cause");
        rd(REG_EPC,    32'h0,         "rst_epc");
        check("rst_intr", 32'(intr_req), 32'h0);
        step();
        rd(REG_PRID,     PRID,  "rst_prid");
        rd(REG_CONFIG,   CONFIG, "rst_config");
        rd(REG_BADVADDR, 32'h0, "rst_badva");
        rd(5'd3,         32'h0, "unlisted");
        resetn = 1'b1;
        step();

        // Masked Status write, forwarded then registered
        wen = 1'b1; waddr = REG_STATUS; wdata = 32'hFFFF_FFFF; raddr = REG_STATUS;
        #1;
        check("status_fwd_rdata", rdata, 32'h1040_FF07);
        check("status_fwd_out", cp0_Status, 32'h1040_FF07);
        step();
        wen = 1'b0;
        rd(REG_STATUS, 32'h1040_FF07, "status_masked");

        // Masked Cause write; EXL/ERL block the software interrupt
        mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        rd(REG_CAUSE, 32'h0080_0300, "cause_masked");
        check("intr_blocked_exl", 32'(intr_req), 32'h0);
        mtc0(REG_CAUSE, 32'h0);
        mtc0(REG_BADVADDR, 32'h1234_5678);
        rd(REG_BADVADDR, 32'h0, "badva_ro");
        mtc0(REG_STATUS, 32'h0040_0000);

        // Syscall in delay slot, then nested Bp keeps EPC and BD
        commit(EXC_SYSC, 32'hBFC0_0100, 1'b1, 1'b0, 32'h0, 2'd0);
        rd(REG_EPC,    32'hBFC0_00FC, "sys_epc");
        rd(REG_CAUSE,  32'h8000_0020, "sys_cause");
        rd(REG_STATUS, 32'h0040_0002, "sys_status");
        commit(EXC_BP, 32'h1234_0000, 1'b0, 1'b0, 32'h0, 2'd0);
        rd(REG_EPC,    32'hBFC0_00FC, "nested_epc");
        rd(REG_CAUSE,  32'h8000_0024, "nested_cause");

        // ERET with same-cycle MTC0 EPC
        wen = 1'b1; waddr = REG_EPC; wdata = 32'h8000_0040;
        exc_flag = 1'b1; exc_type = EXC_ERET;
        #1;
        check("eret_epc_fwd", cp0_EPC, 32'h8000_0040);
        step();
        wen = 1'b0; exc_flag = 1'b0;
        rd(REG_STATUS, 32'h0040_0000, "eret_status");
        rd(REG_EPC,    32'h8000_0040, "eret_epc");

        // AdE store captures BadVAddr; CpU while EXL keeps it
        commit(EXC_ADE, 32'hBFC0_0200, 1'b0, 1'b1, 32'h0000_0003, 2'd0);
        rd(REG_BADVADDR, 32'h0000_0003, "ade_badva");
        rd(REG_CAUSE,    32'h0000_0014, "ade_cause");
        rd(REG_EPC,      32'hBFC0_0200, "ade_epc");
        commit(EXC_CPU, 32'hBFC0_0300, 1'b1, 1'b0, 32'h0000_DEAD, 2'd2);
        rd(REG_CAUSE,    32'h2000_002C, "cpu_cause");
        rd(REG_BADVADDR, 32'h0000_0003, "cpu_badva_kept");
        rd(REG_EPC,      32'hBFC0_0200, "cpu_epc_kept");

        // Hardware interrupt line 0 through IM2
        mtc0(REG_STATUS, 32'h0000_0401);
        int_i = 6'b000001;
        #1;
        check("hwint_before", 32'(intr_req), 32'h0);
        step();
        check("hwint_after", 32'(intr_req), 32'h1);
        rd(REG_CAUSE, 32'h2000_042C, "hwint_cause");
        int_i = 6'b000000;
        step();
        check("hwint_drop", 32'(intr_req), 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(REG_COUNT, 32'h0);
        mtc0(REG_COMPARE, 32'd10);
        mtc0(REG_STATUS, 32'h0000_8001);
        begin
            int waited;
            waited = 0;
            while (!intr_req && waited < 60) begin
                step();
                waited++;
            end
        end
        check("timer_irq", 32'(intr_req), 32'h1);
        rd(REG_COUNT, 32'd10,        "timer_count");
        rd(REG_CAUSE, 32'h6000_802C, "timer_cause");
        mtc0(REG_COMPARE, 32'd20);
        check("timer_clear_irq", 32'(intr_req), 32'h0);
        rd(REG_CAUSE, 32'h2000_002C, "timer_clear_cause");
        mtc0(REG_COUNT, 32'hFFFF_FFFF);
        rd(REG_COUNT, 32'hFFFF_FFFF, "count_load");
        step();
        step();
        rd(REG_COUNT, 32'h0, "count_wrap");
`else
        mtc0(REG_COUNT, 32'd5);
        rd(REG_COUNT,   32'h0, "no_timer_count");
        mtc0(REG_COMPARE, 32'd7);
        rd(REG_COMPARE, 32'h0, "no_timer_compare");
        check("no_timer_irq", 32'(intr_req), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file and exception-commit unit; sits directly upstream of the pipeline control block. It commits exceptions raised in MEM, executes ERET side effects, services MTC0/MFC0, runs the Count/Compare timer and raises the pending-interrupt request. It exports the Status, Cause, EPC and ErrorEPC views that the control block uses to compute flush vectors.

## Interface
- PRID, 32'h0001_8000, constant returned for PRId (reg 15).
- CONFIG, 32'h8000_0000, constant returned for Config (reg 16).
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- int_i  in  6  hardware interrupt lines, level, map to Cause.IP[7:2].
- wen  in  1  MTC0 write strobe (WB stage).
- waddr  in  5  CP0 register number for write; sel fixed 0.
- wdata  in  32  write data.
- raddr  in  5  CP0 register number for MFC0 read.
- rdata  out  32  combinational read data.
- exc_flag  in  1  MEM-stage exception/ERET commit strobe.
- exc_type  in  ExcType  exception kind (shared package encoding).
- exc_pc  in  32  PC of faulting instruction.
- exc_ds  in  1  faulting instruction is in a delay slot.
- exc_store  in  1  faulting access was a store (AdE/TLB code select).
- exc_badva  in  32  faulting virtual address.
- exc_ce  in  2  coprocessor number for CpU.
- intr_req  out  1  interrupt pending and enabled.
- cp0_Status, cp0_Cause, cp0_EPC, cp0_ErrorEPC  out  32 each  forwarded views.

## Operation
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15), Config(16), ErrorEPC(30). Unlisted addresses read 0, writes ignored.
- Reset: Status=32'h0040_0004 (BEV=1, ERL=1), all other storage 0, intr_req=0.
- Status writable mask 32'h1040_FF07 (CU0, BEV, IM, ERL, EXL, IE); Cause writable mask 32'h0080_0300 (IV, IP[1:0]); EPC, ErrorEPC, Count, Compare fully writable; BadVAddr read-only.
- Cause.IP[7:2] <= int_i registered each cycle; IP[7] additionally OR'd with Cause.TI (bit 30).
- Exception commit (exc_flag, type not ERET): if Status.EXL==0, EPC <= exc_ds ? exc_pc-4 : exc_pc and Cause.BD <= exc_ds; if EXL==1, EPC and BD unchanged. Status.EXL <= 1. Cause.ExcCode <= Intr 0, TLBM 1, TLBR/TLBI 2/3 (load/store), AdE 4/5, SysC 8, Bp 9, RI 10, CpU 11 (Cause.CE <= exc_ce), Ov 12, Trap 13. BadVAddr <= exc_badva for AdE, TLBR, TLBI, TLBM only.
- ERET commit: if ERL, ERL <= 0; else EXL <= 0.
- Same-cycle MTC0 and commit: MTC0 applied first, commit overrides the fields it touches.
- intr_req = Status.IE & ~EXL & ~ERL & |(Cause.IP & Status.IM).
- rdata and cp0_* outputs forward a same-cycle wen write to the matching register (masked) so ERET in MEM sees an MTC0 in WB.

## Timing
- Writes and commits visible in registers one cycle later; forwarded outputs same cycle.
- int_i to intr_req: one cycle.
- Count increments once every two cycles (internal toggle flop, reset 0); wraps 32'hFFFF_FFFF to 0. MTC0 to Count loads value and resets toggle.
- TI sets on the tick where Count == Compare; cleared only by MTC0 to Compare (same cycle write wins over set).

## Configuration
- CP0_TIMER_EN defined: Count/Compare, toggle and TI logic present.
- Undefined: Count and Compare read 0, writes ignored, TI constant 0, IP[7] follows int_i[5] only.

## Structure
- Shared package: ExcType width/encodings, CP0 register numbers, Status/Cause bit indices (BEV, EXL, ERL, IE, IV, BD, TI), ExcCode constants, write masks.
- One sub-module: cp0_timer (Count, Compare, toggle, TI), instantiated under CP0_TIMER_EN.

## Test plan
- Reset, read reg 12 -> 32'h0040_0004; reg 13, 14 -> 0; reg 15 -> PRID.
- MTC0 Status=32'hFFFF_FFFF -> reads 32'h1040_FF07; MTC0 Cause=32'hFFFF_FFFF -> only bits 23, 9, 8 set.
- Syscall commit exc_pc=32'hBFC0_0100, exc_ds=1, EXL=0 -> EPC=32'hBFC0_00FC, BD=1, ExcCode=8, EXL=1; second commit with EXL=1 leaves EPC.
- MTC0 EPC=32'h8000_0040 in WB with ERET commit same cycle -> cp0_EPC shows 32'h8000_0040 that cycle; EXL cleared next cycle (ERL already 0).
- Compare=10, Status IE=1, IM7=1, EXL=ERL=0 -> TI and intr_req after Count reaches 10 (~20 cycles); MTC0 Compare clears TI and intr_req.
- AdE store commit exc_badva=32'h0000_0003 -> BadVAddr=32'h3, ExcCode=5; int_i=6'b000001 with IM2, IE set -> intr_req next cycle.
